// File: rtl/pista_scroller_if.sv
// Signal bundle between the scroller, its driver side and the pattern ROM.
// The scroller owns obs_sel/digits/colision/bonus_pts/game_over/dbg_state.
interface pista_scroller_if #(
    parameter int N_DIG = 4
);
    // step is a single-cycle request with no ready: it is taken only when the
    // scroller is idle, enabled and not game over, and dropped otherwise.
    logic                 en;
    logic                 step;
    logic [3:0]           rnd;
    logic [6:0]           hero_seg;
    logic [3:0]           obs_sel;
    logic [6:0]           obstaculos;
    logic [N_DIG*7-1:0]   digits;
    logic                 colision;
    logic [5:0]           bonus_pts;
    logic                 game_over;
    logic [1:0]           dbg_state;

    modport master (
        output en, step, rnd, hero_seg, obstaculos,
        input  obs_sel, digits, colision, bonus_pts, game_over, dbg_state
    );

    modport slave (
        input  en, step, rnd, hero_seg, obstaculos,
        output obs_sel, digits, colision, bonus_pts, game_over, dbg_state
    );
endinterface

// File: rtl/pista_scroller.sv
// Track scroller: picks a ROM code per step, waits out the ROM latency, shifts
// the pattern into the digit buffer and scores digit 0. Option: PISTA_VIDAS_EN.
module pista_scroller #(
    parameter int N_DIG = 4,
    parameter int GAP   = 1,
    parameter int VIDAS = 3
) (
    input  logic             clk,
    input  logic             rst,
    pista_scroller_if.slave  bus
);
    localparam int GW = $clog2(GAP + 2);

    if (N_DIG < 2 || VIDAS < 1) begin : g_bad_cfg
        $error("pista_scroller: needs N_DIG >= 2 and VIDAS >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT1 = 2'd1,
        S_WAIT2 = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_shift;

    logic [3:0]             r_obs_sel;
    logic [3:0]             r_entry;
    logic [6:0]             r_cap;
    logic [N_DIG-1:0][6:0]  r_dig;
    logic [N_DIG-1:0][3:0]  r_code;
    logic [GW-1:0]          r_gap;
    logic                   r_col;
    logic [5:0]             r_bonus;
    logic                   r_go;

    logic [6:0]             w_in_pat;
    logic [3:0]             w_in_code;
    logic                   w_in_hit;
    logic                   w_in_obs;
    logic                   w_in_bonus;
    logic [5:0]             w_in_pts;
    logic                   w_unused;

`ifdef PISTA_VIDAS_EN
    localparam int LW = $clog2(VIDAS + 1);
    logic [LW-1:0]          r_lives;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_shift   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.step && bus.en && !r_go) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT1;
                end
            end
            S_WAIT1: w_next = S_WAIT2;
            S_WAIT2: begin
                w_capture = 1'b1;
                w_next    = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The digit about to become digit 0 is the one currently held in digit 1.
    assign w_in_pat   = r_dig[1];
    assign w_in_code  = r_code[1];
    assign w_in_hit   = |(w_in_pat & bus.hero_seg);
    assign w_in_obs   = (w_in_code <= 4'd9);
    assign w_in_bonus = (w_in_code >= 4'd10) && (w_in_code <= 4'd12);

    always_comb begin
        w_in_pts = 6'd0;
        case (w_in_code)
            4'd10:   w_in_pts = 6'd10;
            4'd11:   w_in_pts = 6'd20;
            4'd12:   w_in_pts = 6'd30;
            default: w_in_pts = 6'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_obs_sel <= 4'd15;
            r_entry   <= 4'd15;
            r_cap     <= '0;
            r_dig     <= '0;
            r_code    <= '1;
            r_gap     <= '0;
            r_col     <= 1'b0;
            r_bonus   <= '0;
            r_go      <= 1'b0;
`ifdef PISTA_VIDAS_EN
            r_lives   <= LW'(VIDAS);
`endif
        end else begin
            r_col   <= 1'b0;
            r_bonus <= '0;

            if (w_accept) begin
                if (r_gap != '0) begin
                    r_obs_sel <= 4'd15;
                    r_entry   <= 4'd15;
                    r_gap     <= r_gap - GW'(1);
                end else begin
                    r_obs_sel <= bus.rnd;
                    r_entry   <= bus.rnd;
                end
            end

            if (w_capture) begin
                r_cap <= bus.obstaculos;
            end

            if (w_shift) begin
                for (int k = 0; k < N_DIG - 1; k++) begin
                    r_dig[k]  <= r_dig[k+1];
                    r_code[k] <= r_code[k+1];
                end
                r_dig[N_DIG-1]  <= r_cap;
                r_code[N_DIG-1] <= r_entry;

                if (w_in_obs && w_in_hit) begin
                    r_col <= 1'b1;
`ifdef PISTA_VIDAS_EN
                    if (r_lives <= LW'(1)) begin
                        r_go <= 1'b1;
                    end
                    if (r_lives != '0) begin
                        r_lives <= r_lives - LW'(1);
                    end
`else
                    r_go <= 1'b1;
`endif
                end else if (w_in_bonus && w_in_hit) begin
                    // A collected bonus leaves a blank hole at the hero.
                    r_bonus   <= w_in_pts;
                    r_dig[0]  <= 7'd0;
                    r_code[0] <= 4'd15;
                end

                if (r_entry <= 4'd12) begin
                    r_gap <= GW'(GAP);
                end
            end
        end
    end

    assign w_unused = ^r_code[0];

    assign bus.obs_sel   = r_obs_sel;
    assign bus.digits    = {r_dig[N_DIG-1:1], r_dig[0] | bus.hero_seg};
    assign bus.colision  = r_col;
    assign bus.bonus_pts = r_bonus;
    assign bus.game_over = r_go;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_pista_scroller.sv
// Bench for pista_scroller: directed scenarios plus random stimulus, with a
// cycle-countdown reference model compared every cycle.
module tb_pista_scroller;
    localparam int N_DIG = 4;
    localparam int GAP   = 1;
    localparam int VIDAS = 3;
    localparam int DW    = N_DIG * 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pista_scroller_if #(.N_DIG(N_DIG)) bus ();

    pista_scroller #(.N_DIG(N_DIG), .GAP(GAP), .VIDAS(VIDAS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_col    = 0;
    logic [3:0] last_sel;

    function automatic logic [6:0] rom_f(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0001111;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b1000001;
            4'd5:    return 7'b0110011;
            4'd6:    return 7'b1011011;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            4'd10:   return 7'b0000110;
            4'd11:   return 7'b1001001;
            4'd12:   return 7'b1111001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Pattern ROM with one registered cycle of latency.
    always @(posedge clk) bus.obstaculos <= rom_f(bus.obs_sel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted step completes its shift three edges later.
    bit         m_valid = 0;
    int         m_busy;
    logic [3:0] m_pend;
    logic [3:0] m_sel;
    int         m_gap;
    logic [6:0] m_pat [N_DIG];
    int         m_code[N_DIG];
    logic       m_col;
    int         m_bonus;
    logic       m_go;
    logic [6:0] t_pat;
    int         t_code;
`ifdef PISTA_VIDAS_EN
    int         m_lives;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
            m_pend  = 4'd15;
            m_sel   = 4'd15;
            m_gap   = 0;
            for (int k = 0; k < N_DIG; k++) begin
                m_pat[k]  = 7'd0;
                m_code[k] = 15;
            end
            m_col   = 1'b0;
            m_bonus = 0;
            m_go    = 1'b0;
`ifdef PISTA_VIDAS_EN
            m_lives = VIDAS;
`endif
        end else begin
            m_col   = 1'b0;
            m_bonus = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    t_pat  = m_pat[1];
                    t_code = m_code[1];
                    for (int k = 0; k < N_DIG - 1; k++) begin
                        m_pat[k]  = m_pat[k+1];
                        m_code[k] = m_code[k+1];
                    end
                    m_pat[N_DIG-1]  = rom_f(m_pend);
                    m_code[N_DIG-1] = int'(m_pend);
                    if ((t_pat & bus.hero_seg) != 7'd0) begin
                        if (t_code <= 9) begin
                            m_col = 1'b1;
`ifdef PISTA_VIDAS_EN
                            m_lives--;
                            if (m_lives == 0) m_go = 1'b1;
`else
                            m_go = 1'b1;
`endif
                        end else if (t_code <= 12) begin
                            m_bonus   = (t_code - 9) * 10;
                            m_pat[0]  = 7'd0;
                            m_code[0] = 15;
                        end
                    end
                    if (m_pend <= 4'd12) m_gap = GAP;
                end
            end else if (bus.step && bus.en && !m_go) begin
                if (m_gap > 0) begin
                    m_pend = 4'd15;
                    m_gap--;
                end else begin
                    m_pend = bus.rnd;
                end
                m_sel  = m_pend;
                m_busy = 3;
            end
        end
    end

    function automatic logic [DW-1:0] model_digits();
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < N_DIG; k++) begin
            v[k*7 +: 7] = (k == 0) ? (m_pat[0] | bus.hero_seg) : m_pat[k];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("m_digits", 64'(bus.digits), 64'(model_digits()));
            chk("m_obs_sel", 64'(bus.obs_sel), 64'(m_sel));
            chk("m_colision", 64'(bus.colision), 64'(m_col));
            chk("m_bonus", 64'(bus.bonus_pts), 64'(m_bonus));
            chk("m_game_over", 64'(bus.game_over), 64'(m_go));
        end
    end

    always @(negedge clk) if (bus.colision === 1'b1) n_col++;

    // Called at a falling edge; returns at the falling edge right after the shift.
    task automatic do_step(input logic [3:0] code);
        bus.rnd  = code;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        last_sel = bus.obs_sel;
        repeat (3) @(negedge clk);
    endtask

    logic [DW-1:0] exp_d;
    logic [DW-1:0] got_d;
    int n_hits;

    initial begin
        bus.en       = 1'b1;
        bus.step     = 1'b0;
        bus.rnd      = 4'd0;
        bus.hero_seg = 7'd0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_digits", 64'(bus.digits), 64'd0);
        chk("rst_obs_sel", 64'(bus.obs_sel), 64'd15);
        chk("rst_game_over", 64'(bus.game_over), 64'd0);
        chk("rst_bonus", 64'(bus.bonus_pts), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: nothing moves until the third edge after acceptance.
        bus.rnd  = 4'd4;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        chk("lat_t0", 64'(bus.digits), 64'd0);
        @(negedge clk);
        chk("lat_t1", 64'(bus.digits), 64'd0);
        @(negedge clk);
        chk("lat_t2", 64'(bus.digits), 64'd0);
        @(negedge clk);
        exp_d = '0;
        exp_d[27:21] = 7'b1000001;
        chk("lat_t3", 64'(bus.digits), 64'(exp_d));

        // Gap insertion: the code-4 entry above leaves one blank pending.
        for (int i = 0; i < 8; i++) begin
            do_step(4'd0);
            chk("gap_sel", 64'(last_sel), (i % 2 == 0) ? 64'd15 : 64'd0);
            repeat (2) @(negedge clk);
        end
        do_step(4'd13);

        // Steps during WAIT1/WAIT2 are dropped.
        bus.rnd  = 4'd5;
        bus.step = 1'b1;
        @(negedge clk);
        bus.rnd  = 4'd7;
        @(negedge clk);
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        chk("drop_sel", 64'(bus.obs_sel), 64'd5);
        repeat (6) @(negedge clk);
        chk("drop_hold", 64'(bus.obs_sel), 64'd5);

        // Reset while the ROM result is in flight.
        bus.rnd  = 4'd6;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_digits", 64'(bus.digits), 64'd0);
        chk("rw_obs_sel", 64'(bus.obs_sel), 64'd15);
        chk("rw_colision", 64'(bus.colision), 64'd0);
        chk("rw_bonus", 64'(bus.bonus_pts), 64'd0);
        chk("rw_game_over", 64'(bus.game_over), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_noshift", 64'(bus.digits), 64'd0);
        repeat (2) @(negedge clk);

        // Bonus pickup of code 12 at the hero.
        bus.hero_seg = 7'b0110000;
        do_step(4'd12);
        do_step(4'd13);
        do_step(4'd13);
        do_step(4'd13);
        chk("bonus_pts", 64'(bus.bonus_pts), 64'd30);
        got_d = bus.digits;
        chk("bonus_digit0", 64'(got_d[6:0]), 64'b0110000);
        @(negedge clk);
        chk("bonus_once", 64'(bus.bonus_pts), 64'd0);

        // Obstacle hits.
        bus.hero_seg = 7'b0000001;
        n_col = 0;
`ifdef PISTA_VIDAS_EN
        n_hits = VIDAS;
`else
        n_hits = 1;
`endif
        for (int h = 0; h < n_hits; h++) begin
            do_step(4'd0);
            do_step(4'd13);
            do_step(4'd13);
            do_step(4'd13);
            chk("hit_pulse", 64'(bus.colision), 64'd1);
            chk("hit_game_over", 64'(bus.game_over), (h == n_hits - 1) ? 64'd1 : 64'd0);
            @(negedge clk);
            chk("hit_once", 64'(bus.colision), 64'd0);
        end
        chk("hit_count", 64'(n_col), 64'(n_hits));
        do_step(4'd5);
        chk("frozen_sel", 64'(bus.obs_sel), 64'd13);
        chk("frozen_go", 64'(bus.game_over), 64'd1);

        // Random phase.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst          = (m_go && $urandom_range(0, 15) == 0) || ($urandom_range(0, 499) == 0);
            bus.en       = ($urandom_range(0, 7) != 0);
            bus.step     = ($urandom_range(0, 2) == 0);
            bus.rnd      = 4'($urandom_range(0, 15));
            bus.hero_seg = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
        end
        rst      = 1'b0;
        bus.step = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
